// File: rtl/adc_pkg.sv
// Shared types and default-rate constants for the serial ADC capture path.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    QUIET
  } adc_state_t;

  localparam int unsigned FRAME_BITS         = 16;
  localparam int unsigned ADC_SCLK_DIV       = 2;
  localparam int unsigned ADC_SAMPLE_DIV_20K = 2500;

endpackage

// File: rtl/adc_spi_reader_sclk_gen.sv
// SCLK generator: square wave starting in the high phase, with edge strobes and bit count.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = ADC_SCLK_DIV
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic run,
  output logic adc_sclk,
  output logic rise_stb,
  output logic fall_stb,
  output logic last_edge
);
  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [HW-1:0] half_cnt;
  logic [4:0]    bit_cnt;
  logic          half_done;

  // The SETUP phase is simply the first high half-period, so the FSM's first
  // SHIFT cycle coincides with the first falling edge.
  always_comb begin
    half_done = run && (half_cnt == HW'(CLK_DIV - 1));
    rise_stb  = half_done && !adc_sclk;
    last_edge = half_done && adc_sclk && (bit_cnt == 5'(FRAME_BITS));
    fall_stb  = half_done && adc_sclk && !last_edge;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      adc_sclk <= 1'b1;
    end else if (!run || last_edge) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      adc_sclk <= 1'b1;
    end else begin
      half_cnt <= half_done ? '0 : half_cnt + 1'b1;
      if (half_done) adc_sclk <= ~adc_sclk;
      if (rise_stb)  bit_cnt  <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master reading a 16-bit AD7476-class frame at a fixed rate; emits a
// parallel sample with a one-cycle valid strobe plus framing/overrun pulses.
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV      = ADC_SCLK_DIV,
  parameter int unsigned SAMPLE_DIV   = ADC_SAMPLE_DIV_20K,
  parameter int unsigned QUIET_CYCLES = 4,
  parameter int unsigned LEAD_ZEROS   = 4,
  parameter int unsigned DATA_W       = 12,
  parameter bit          RATE_GUARD   = 1'b1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              adc_sdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              frame_err,
  output logic              overrun
);
  localparam int unsigned TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);

  if (CLK_DIV < 2 || QUIET_CYCLES < 1 || LEAD_ZEROS + DATA_W != FRAME_BITS) begin : g_cfg_err
    $error("adc_spi_reader: invalid CLK_DIV/QUIET_CYCLES/frame layout");
  end
  if (RATE_GUARD && SAMPLE_DIV < 33 * CLK_DIV + QUIET_CYCLES + 2) begin : g_rate_err
    $error("adc_spi_reader: SAMPLE_DIV too small for one frame plus quiet time");
  end

  adc_state_t            state, state_nxt;
  logic [TW-1:0]         tick_cnt;
  logic [QW-1:0]         quiet_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  tick, run, cs_n_nxt;
  logic                  rise_stb, fall_stb, last_edge;

  assign tick = en && (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign run  = (state == SETUP) || (state == SHIFT);

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .run      (run),
    .adc_sclk (adc_sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .last_edge(last_edge)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick)      state_nxt = SETUP;
      SETUP:   if (fall_stb)  state_nxt = SHIFT;
      SHIFT:   if (last_edge) state_nxt = QUIET;
      QUIET:   if (quiet_cnt == QW'(QUIET_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    cs_n_nxt = !((state_nxt == SETUP) || (state_nxt == SHIFT));
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      quiet_cnt    <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state     <= state_nxt;
      adc_cs_n  <= cs_n_nxt;
      tick_cnt  <= (!en || tick) ? '0 : tick_cnt + 1'b1;
      quiet_cnt <= (state == QUIET) ? quiet_cnt + 1'b1 : '0;
      if (rise_stb) shreg <= {shreg[FRAME_BITS-2:0], adc_sdata};
      // last_edge fires once per frame, after all 16 bits are in shreg.
      sample_valid <= last_edge;
      frame_err    <= last_edge && (shreg[FRAME_BITS-1 -: LEAD_ZEROS] != '0);
      overrun      <= tick && (state != IDLE);
      if (last_edge) sample <= shreg[DATA_W-1:0];
    end
  end

endmodule
